occf_wb_stream_sink: RTL and testbench

- Wishbone pipelined-slave stream sink for the Open Communication Controller fabric.
- Accepts 128-bit write cycles from an upstream fabric source. Each WB cycle (CYC high period) is one packet.
- Buffers words in a FIFO and presents them on a simple valid/request streaming interface with start/end-of-packet flags, address and byte-select.
- Sits between the fabric's WB master (packet source) and downstream OCC processing logic.

---
 rtl/occf_wb_stream_sink_if.sv | 32 +++
 rtl/occf_wb_stream_sink.sv | 143 ++++++++++++++
 tb/tb_occf_wb_stream_sink.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/occf_wb_stream_sink_if.sv
// Wishbone pipelined-slave sink bus plus downstream word stream, bundled for occf_wb_stream_sink.
interface occf_wb_stream_sink_if;
  logic [127:0] snk_dat_i;
  logic [3:0]   snk_adr_i;
  logic [15:0]  snk_sel_i;
  logic         snk_cyc_i;
  logic         snk_stb_i;
  logic         snk_we_i;
  logic         snk_stall_o;
  logic         snk_ack_o;
  logic         snk_err_o;
  logic         snk_rty_o;
  logic [3:0]   addr_o;
  logic [127:0] data_o;
  logic         dvalid_o;
  logic         sof_o;
  logic         eof_o;
  logic [15:0]  bytesel_o;
  logic         dreq_i;

  modport slave (
    input  snk_dat_i, snk_adr_i, snk_sel_i, snk_cyc_i, snk_stb_i, snk_we_i, dreq_i,
    output snk_stall_o, snk_ack_o, snk_err_o, snk_rty_o,
    output addr_o, data_o, dvalid_o, sof_o, eof_o, bytesel_o
  );

  modport master (
    output snk_dat_i, snk_adr_i, snk_sel_i, snk_cyc_i, snk_stb_i, snk_we_i, dreq_i,
    input  snk_stall_o, snk_ack_o, snk_err_o, snk_rty_o,
    input  addr_o, data_o, dvalid_o, sof_o, eof_o, bytesel_o
  );
endinterface

// File: rtl/occf_wb_stream_sink.sv
// WB pipelined write sink: one CYC period per packet, words buffered through a holding register
// and FIFO, then streamed out with sof/eof flags as one dvalid pulse per word.
module occf_wb_stream_sink #(
  parameter int G_FIFO_DEPTH         = 8,
  parameter int G_WITH_FIFO_INFERRED = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  occf_wb_stream_sink_if.slave bus
);
  localparam int DATA_W = 128;
  localparam int ADR_W  = 4;
  localparam int SEL_W  = 16;
  localparam int PTR_W  = $clog2(G_FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] dat;
    logic [SEL_W-1:0]  sel;
    logic              sof;
    logic              eof;
  } word_t;

  logic             accept, capture, push, pop;
  logic             stall_p0, ack_p0, sof_pend_p0, hold_full_p0;
  word_t            hold_p0, push_word, fifo_word;
  logic [PTR_W-1:0] wr_ptr_p1, rd_ptr_p1;
  logic [CNT_W-1:0] count_p1;

  logic              vld_p2, sof_p2, eof_p2;
  logic [ADR_W-1:0]  addr_p2;
  logic [DATA_W-1:0] data_p2;
  logic [SEL_W-1:0]  sel_p2;

  assign accept  = bus.snk_cyc_i & bus.snk_stb_i & ~stall_p0;
  assign capture = accept & bus.snk_we_i;
  // The held word leaves when the next word displaces it, or as the packet tail once CYC drops.
  assign push    = hold_full_p0 & (capture | ~bus.snk_cyc_i);
  assign pop     = bus.dreq_i & (count_p1 != '0);

  always_comb begin
    push_word     = hold_p0;
    push_word.eof = ~bus.snk_cyc_i;
  end

  // Stage p0: WB handshake and holding register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_p0       <= 1'b0;
      stall_p0     <= 1'b0;
      hold_full_p0 <= 1'b0;
      sof_pend_p0  <= 1'b1;
    end else begin
      ack_p0   <= accept;
      stall_p0 <= (count_p1 >= CNT_W'(G_FIFO_DEPTH - 2));
      if (capture) begin
        hold_full_p0 <= 1'b1;
        sof_pend_p0  <= 1'b0;
      end else if (push) begin
        hold_full_p0 <= 1'b0;
      end
      if (!bus.snk_cyc_i) sof_pend_p0 <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (capture) begin
      hold_p0.adr <= bus.snk_adr_i;
      hold_p0.dat <= bus.snk_dat_i;
      hold_p0.sel <= bus.snk_sel_i;
      hold_p0.sof <= sof_pend_p0;
      hold_p0.eof <= 1'b0;
    end
  end

  // Stage p1: FIFO pointers and storage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_p1 <= '0;
      rd_ptr_p1 <= '0;
      count_p1  <= '0;
    end else begin
      if (push) wr_ptr_p1 <= wr_ptr_p1 + 1'b1;
      if (pop)  rd_ptr_p1 <= rd_ptr_p1 + 1'b1;
      case ({push, pop})
        2'b10:   count_p1 <= count_p1 + 1'b1;
        2'b01:   count_p1 <= count_p1 - 1'b1;
        default: count_p1 <= count_p1;
      endcase
    end
  end

  generate
    if (G_WITH_FIFO_INFERRED != 0) begin : g_ram
      word_t mem [G_FIFO_DEPTH];
      always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_p1] <= push_word;
      end
      assign fifo_word = mem[rd_ptr_p1];
    end else begin : g_regs
      word_t regs [G_FIFO_DEPTH];
      always_ff @(posedge clk_i) begin
        for (int i = 0; i < G_FIFO_DEPTH; i++) begin
          if (push && (wr_ptr_p1 == PTR_W'(i))) regs[i] <= push_word;
        end
      end
      assign fifo_word = regs[rd_ptr_p1];
    end
  endgenerate

  // Stage p2: output register, data held between pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p2  <= 1'b0;
      sof_p2  <= 1'b0;
      eof_p2  <= 1'b0;
      addr_p2 <= '0;
      data_p2 <= '0;
      sel_p2  <= '0;
    end else begin
      vld_p2 <= pop;
      sof_p2 <= pop & fifo_word.sof;
      eof_p2 <= pop & fifo_word.eof;
      if (pop) begin
        addr_p2 <= fifo_word.adr;
        data_p2 <= fifo_word.dat;
        sel_p2  <= fifo_word.sel;
      end
    end
  end

  assign bus.snk_stall_o = stall_p0;
  assign bus.snk_ack_o   = ack_p0;
  assign bus.snk_err_o   = 1'b0;
  assign bus.snk_rty_o   = 1'b0;
  assign bus.dvalid_o    = vld_p2;
  assign bus.sof_o       = sof_p2;
  assign bus.eof_o       = eof_p2;
  assign bus.addr_o      = addr_p2;
  assign bus.data_o      = data_p2;
  assign bus.bytesel_o   = sel_p2;
endmodule

// File: tb/tb_occf_wb_stream_sink.sv
// Directed bench for occf_wb_stream_sink: reset, packets, back-to-back, 1-word, stall/drain, empty CYC.
module tb_occf_wb_stream_sink;
  typedef struct packed {
    logic [3:0]   adr;
    logic [127:0] dat;
    logic [15:0]  sel;
    logic         sof;
    logic         eof;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  occf_wb_stream_sink_if bus();

  occf_wb_stream_sink #(
    .G_FIFO_DEPTH(8),
    .G_WITH_FIFO_INFERRED(1)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  int    tests = 0;
  int    fails = 0;
  word_t exp_q[$];
  word_t obs_q[$];
  int    obs_t[$];
  int    cyc_n = 0;
  int    ack_cnt = 0;
  int    ack_err = 0;
  int    flag_err = 0;
  int    acc_total = 0;
  logic  acc_prev = 1'b0;

  always @(posedge clk) cyc_n++;

  always @(negedge clk) begin
    word_t o;
    if (bus.dvalid_o === 1'b1) begin
      o.adr = bus.addr_o;
      o.dat = bus.data_o;
      o.sel = bus.bytesel_o;
      o.sof = bus.sof_o;
      o.eof = bus.eof_o;
      obs_q.push_back(o);
      obs_t.push_back(cyc_n);
    end else if (bus.sof_o !== 1'b0 || bus.eof_o !== 1'b0) begin
      flag_err++;
    end
    if (!rst) begin
      if (bus.snk_ack_o !== acc_prev) ack_err++;
      if (bus.snk_ack_o === 1'b1) ack_cnt++;
    end
    acc_prev = !rst && bus.snk_cyc_i && bus.snk_stb_i && !bus.snk_stall_o;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send_pkt(input int n, input int mode, output int acc_first);
    word_t w[$];
    int    idx;
    int    guard;
    logic  acc;
    for (int i = 0; i < n; i++) begin
      word_t x;
      if (mode == 0) begin
        x.adr = 4'(i);
        x.dat = {4{32'hC0DE_0000 + 32'(i)}};
        x.sel = 16'hFFFF;
      end else begin
        x.adr = 4'($urandom);
        x.dat = {$urandom, $urandom, $urandom, $urandom};
        x.sel = 16'($urandom);
      end
      x.sof = (i == 0);
      x.eof = (i == n - 1);
      w.push_back(x);
      exp_q.push_back(x);
    end
    @(posedge clk); #1;
    bus.snk_cyc_i = 1'b1;
    idx = 0;
    guard = 0;
    acc_first = -1;
    while (idx < n && guard < 1000) begin
      bus.snk_stb_i = 1'b1;
      bus.snk_we_i  = 1'b1;
      bus.snk_adr_i = w[idx].adr;
      bus.snk_dat_i = w[idx].dat;
      bus.snk_sel_i = w[idx].sel;
      @(negedge clk);
      acc = !bus.snk_stall_o;
      @(posedge clk); #1;
      if (acc) begin
        if (idx == 0) acc_first = cyc_n;
        idx++;
        acc_total++;
      end
      guard++;
    end
    bus.snk_stb_i = 1'b0;
    bus.snk_cyc_i = 1'b0;
    tests++;
    if (idx !== n) begin
      fails++;
      $display("FAIL send_pkt accepted=%0d required=%0d", idx, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_obs(input int n);
    for (int k = 0; k < 600 && obs_q.size() < n; k++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      bus.snk_cyc_i = 1'($urandom);
      bus.snk_stb_i = 1'($urandom);
      bus.snk_we_i  = 1'($urandom);
      bus.snk_adr_i = 4'($urandom);
      bus.snk_sel_i = 16'($urandom);
      bus.snk_dat_i = {$urandom, $urandom, $urandom, $urandom};
      bus.dreq_i    = 1'($urandom);
      @(negedge clk);
      tests++;
      if ({bus.snk_ack_o, bus.snk_stall_o, bus.dvalid_o, bus.sof_o, bus.eof_o} !== 5'b0 ||
          bus.addr_o !== 4'h0 || bus.data_o !== 128'h0 || bus.bytesel_o !== 16'h0) begin
        fails++;
        $display("FAIL reset_outputs cycle %0d: ack=%b stall=%b dvalid=%b sof=%b eof=%b addr=%h sel=%h required all 0",
                 c, bus.snk_ack_o, bus.snk_stall_o, bus.dvalid_o, bus.sof_o, bus.eof_o, bus.addr_o, bus.bytesel_o);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.snk_cyc_i = 1'b0;
    bus.snk_stb_i = 1'b0;
    bus.snk_we_i  = 1'b0;
    bus.dreq_i    = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if (obs_q.size() !== 0) begin
      fails++;
      $display("FAIL reset_no_output got %0d words required 0", obs_q.size());
    end
    obs_q.delete();
    obs_t.delete();
  endtask

  task automatic test_single;
    int af;
    int ack0;
    ack0 = ack_cnt;
    send_pkt(4, 0, af);
    wait_obs(4);
    tests++;
    if (obs_q.size() !== 4) begin
      fails++;
      $display("FAIL single_count got %0d required 4", obs_q.size());
    end else begin
      tests++;
      if (obs_t[0] - af !== 2) begin
        fails++;
        $display("FAIL single_latency got %0d required 2 edges after accept", obs_t[0] - af);
      end
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL single_word %0d got %h required %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    tests++;
    if (ack_cnt - ack0 !== 4) begin
      fails++;
      $display("FAIL single_acks got %0d required 4", ack_cnt - ack0);
    end
    obs_q.delete(); obs_t.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back;
    int af;
    int total;
    int nsof;
    int neof;
    total = 0;
    for (int p = 0; p < 4; p++) begin
      int n;
      n = $urandom_range(4, 16);
      total += n;
      send_pkt(n, 1, af);
    end
    wait_obs(total);
    tests++;
    if (obs_q.size() !== total) begin
      fails++;
      $display("FAIL b2b_count got %0d required %0d", obs_q.size(), total);
    end else begin
      nsof = 0;
      neof = 0;
      for (int i = 0; i < total; i++) begin
        nsof += obs_q[i].sof;
        neof += obs_q[i].eof;
        tests++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL b2b_word %0d got %h required %h", i, obs_q[i], exp_q[i]);
        end
      end
      tests++;
      if (nsof !== 4 || neof !== 4) begin
        fails++;
        $display("FAIL b2b_flags got sof=%0d eof=%0d required 4 and 4", nsof, neof);
      end
    end
    obs_q.delete(); obs_t.delete(); exp_q.delete();
  endtask

  task automatic test_one_word;
    int af;
    send_pkt(1, 1, af);
    wait_obs(1);
    repeat (3) @(negedge clk);
    tests++;
    if (obs_q.size() !== 1) begin
      fails++;
      $display("FAIL one_word_count got %0d required 1", obs_q.size());
    end else begin
      tests++;
      if (obs_q[0] !== exp_q[0] || obs_q[0].sof !== 1'b1 || obs_q[0].eof !== 1'b1) begin
        fails++;
        $display("FAIL one_word got %h required %h", obs_q[0], exp_q[0]);
      end
    end
    obs_q.delete(); obs_t.delete(); exp_q.delete();
  endtask

  task automatic test_stall;
    int af;
    int base;
    int ack0;
    base = acc_total;
    ack0 = ack_cnt;
    bus.dreq_i = 1'b0;
    fork
      send_pkt(16, 1, af);
      begin
        for (int k = 0; k < 300 && bus.snk_stall_o !== 1'b1; k++) @(negedge clk);
        tests++;
        if (bus.snk_stall_o !== 1'b1 || acc_total - base !== 8) begin
          fails++;
          $display("FAIL stall_point stall=%b accepted=%0d required stall=1 after 8", bus.snk_stall_o, acc_total - base);
        end
        repeat (5) @(negedge clk);
        tests++;
        if (bus.snk_stall_o !== 1'b1 || acc_total - base !== 8 || ack_cnt - ack0 !== 8) begin
          fails++;
          $display("FAIL stall_hold stall=%b accepted=%0d acks=%0d required 1/8/8",
                   bus.snk_stall_o, acc_total - base, ack_cnt - ack0);
        end
        tests++;
        if (obs_q.size() !== 0) begin
          fails++;
          $display("FAIL stall_no_output got %0d words required 0", obs_q.size());
        end
        @(posedge clk); #1;
        bus.dreq_i = 1'b1;
      end
    join
    wait_obs(16);
    tests++;
    if (obs_q.size() !== 16) begin
      fails++;
      $display("FAIL drain_count got %0d required 16", obs_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        tests++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL drain_word %0d got %h required %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    obs_q.delete(); obs_t.delete(); exp_q.delete();
  endtask

  task automatic test_empty_cyc;
    int af;
    @(posedge clk); #1;
    bus.snk_cyc_i = 1'b1;
    bus.snk_stb_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    bus.snk_cyc_i = 1'b0;
    repeat (6) @(negedge clk);
    tests++;
    if (obs_q.size() !== 0) begin
      fails++;
      $display("FAIL empty_cyc got %0d words required 0", obs_q.size());
    end
    send_pkt(4, 1, af);
    wait_obs(4);
    tests++;
    if (obs_q.size() !== 4) begin
      fails++;
      $display("FAIL after_empty_count got %0d required 4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL after_empty_word %0d got %h required %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    obs_q.delete(); obs_t.delete(); exp_q.delete();
  endtask

  task automatic test_protocol;
    tests++;
    if (ack_err !== 0 || ack_cnt !== acc_total) begin
      fails++;
      $display("FAIL ack_protocol ack_errors=%0d acks=%0d required 0 errors and %0d acks", ack_err, ack_cnt, acc_total);
    end
    tests++;
    if (flag_err !== 0) begin
      fails++;
      $display("FAIL flag_qualify got %0d unqualified sof/eof required 0", flag_err);
    end
    tests++;
    if (bus.snk_err_o !== 1'b0 || bus.snk_rty_o !== 1'b0) begin
      fails++;
      $display("FAIL err_rty got %b%b required 00", bus.snk_err_o, bus.snk_rty_o);
    end
  endtask

  initial begin
    bus.snk_cyc_i = 1'b0;
    bus.snk_stb_i = 1'b0;
    bus.snk_we_i  = 1'b0;
    bus.snk_adr_i = '0;
    bus.snk_dat_i = '0;
    bus.snk_sel_i = '0;
    bus.dreq_i    = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_one_word();
    test_stall();
    test_empty_cyc();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
